// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receive front end.
//   Recovers frames (1 start, 8 data LSB-first, 1 stop) from the rx pin and
//   hands each byte over on a valid/ready handshake.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   baud_div   bit period is baud_div+1 clocks (latched at start detection)
//   enable     receive enable; low aborts any frame in progress
//   rx         asynchronous serial input, idle high
//   rx_data    received byte, stable while rx_valid is high
//   rx_valid   byte available
//   rx_ready   consumer accepts the byte when rx_valid && rx_ready
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: completed byte dropped, holding register full
//   busy       receiver is not idle
module uart_rx #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             enable,
   input  logic             rx,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             busy_q, busy_d;

   logic             rx_s;
   logic             tick_s;
   logic             deliver_s;
   logic             hs_s;

   assign rx_s      = sync2_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;

   // Next-state logic: synchronizer, bit timing, frame sequencing and handshake.
   always_comb begin
      state_d     = state_q;
      sync1_d     = rx;
      sync2_d     = sync1_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      deliver_s   = 1'b0;
      // A zero count marks the sample point of the current bit.
      tick_s      = (cnt_q == {DIV_W{1'b0}});
      hs_s        = rx_valid_q && rx_ready;

      if (!enable) begin
         // Disabling drops any partial frame silently; the held byte stays.
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_d = ST_START;
                  // Half a period puts the start check in the middle of the bit.
                  cnt_d   = baud_div >> 1;
                  div_d   = baud_div;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_START: begin
               if (!tick_s) begin
                  cnt_d = cnt_q - DIV_W'(1);
               end else begin
                  cnt_d = div_q;
                  if (!rx_s) begin
                     state_d   = ST_DATA;
                     bit_idx_d = 3'd0;
                  end else begin
                     // Line went back high: a glitch, not a start bit.
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_DATA: begin
               if (!tick_s) begin
                  cnt_d = cnt_q - DIV_W'(1);
               end else begin
                  cnt_d     = div_q;
                  shift_d   = {rx_s, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_d = ST_STOP;
                  end else begin
                     state_d = ST_DATA;
                  end
               end
            end
            ST_STOP: begin
               if (!tick_s) begin
                  cnt_d = cnt_q - DIV_W'(1);
               end else begin
                  cnt_d = div_q;
                  if (rx_s) begin
                     deliver_s = 1'b1;
                     state_d   = ST_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = ST_WAIT_HIGH;
                  end
               end
            end
            ST_WAIT_HIGH: begin
               // Keeps a break (line held low) from looking like a new start bit.
               if (rx_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT_HIGH;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // A delivery in the handshake cycle replaces the consumed byte directly.
      if (deliver_s) begin
         if (!rx_valid_q || hs_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (hs_s) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         cnt_q       <= {DIV_W{1'b0}};
         div_q       <= {DIV_W{1'b0}};
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

endmodule
